// File: rtl/hazard_unit.sv
// Pipeline hazard unit: ID-stage dependency detection, load-use/MEM-wait stalls, branch flush.
// Define HAZARD_FWD_EN to build in operand forwarding; otherwise every producer match stalls.
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [4:0]  rd_ID,
  input  logic        rs1use_ID,
  input  logic        rs2use_ID,
  input  logic [1:0]  hazard_optype_ID,
  input  logic        Branch_ID,
  input  logic        dmem_ack,
  output logic [1:0]  forward_ctrl_A,
  output logic [1:0]  forward_ctrl_B,
  output logic        PC_EN_IF,
  output logic        reg_FD_EN,
  output logic        reg_FD_flush,
  output logic        reg_DE_EN,
  output logic        reg_DE_flush,
  output logic        reg_EM_EN,
  output logic        reg_MW_flush,
  output logic [15:0] stall_cnt
);

  localparam logic       ST_RUN      = 1'b0;
  localparam logic       ST_MEM_WAIT = 1'b1;
  localparam logic [1:0] OP_NONE     = 2'b00;
  localparam logic [1:0] OP_ALU      = 2'b01;
  localparam logic [1:0] OP_LOAD     = 2'b10;
  localparam logic [1:0] OP_STORE    = 2'b11;

  logic [4:0]  r_ex_rd, r_mem_rd;
  logic [1:0]  r_ex_op, r_mem_op;
  logic        r_state;
  logic [15:0] r_stall_cnt;

  logic        w_ex_prod, w_mem_prod;
  logic        w_ex_a, w_ex_b, w_mem_a, w_mem_b;
  logic        w_mem_acc, w_mem_wait, w_data_stall;
  logic [2:0]  w_res_a, w_res_b;

  // Returns {stall, forward select} for one operand; the EX hit shadows the MEM hit.
  function automatic logic [2:0] resolve(input logic ex_hit, input logic mem_hit,
                                         input logic ex_load, input logic mem_load);
`ifdef HAZARD_FWD_EN
    if (ex_hit)       resolve = ex_load ? 3'b100 : 3'b001;
    else if (mem_hit) resolve = mem_load ? 3'b011 : 3'b010;
    else              resolve = 3'b000;
`else
    resolve = {(ex_hit || mem_hit || (ex_load && mem_load && 1'b0)), 2'b00};
`endif
  endfunction

  assign w_ex_prod  = ((r_ex_op == OP_ALU) || (r_ex_op == OP_LOAD)) && (r_ex_rd != 5'd0);
  assign w_mem_prod = ((r_mem_op == OP_ALU) || (r_mem_op == OP_LOAD)) && (r_mem_rd != 5'd0);
  assign w_ex_a     = w_ex_prod && rs1use_ID && (rs1_ID == r_ex_rd);
  assign w_ex_b     = w_ex_prod && rs2use_ID && (rs2_ID == r_ex_rd);
  assign w_mem_a    = w_mem_prod && rs1use_ID && (rs1_ID == r_mem_rd);
  assign w_mem_b    = w_mem_prod && rs2use_ID && (rs2_ID == r_mem_rd);

  assign w_res_a = resolve(w_ex_a, w_mem_a, r_ex_op == OP_LOAD, r_mem_op == OP_LOAD);
  assign w_res_b = resolve(w_ex_b, w_mem_b, r_ex_op == OP_LOAD, r_mem_op == OP_LOAD);

  // The ack cycle itself lets the pipeline advance, so the finished access leaves MEM.
  assign w_mem_acc    = (r_mem_op == OP_LOAD) || (r_mem_op == OP_STORE);
  assign w_mem_wait   = (w_mem_acc || (r_state == ST_MEM_WAIT)) && !dmem_ack;
  assign w_data_stall = (w_res_a[2] || w_res_b[2]) && !w_mem_wait;

  always_comb begin
    forward_ctrl_A = 2'b00;
    forward_ctrl_B = 2'b00;
    PC_EN_IF       = 1'b1;
    reg_FD_EN      = 1'b1;
    reg_FD_flush   = 1'b0;
    reg_DE_EN      = 1'b1;
    reg_DE_flush   = 1'b0;
    reg_EM_EN      = 1'b1;
    reg_MW_flush   = 1'b0;
    if (rst) begin
      forward_ctrl_A = w_res_a[1:0];
      forward_ctrl_B = w_res_b[1:0];
      if (w_mem_wait) begin
        PC_EN_IF     = 1'b0;
        reg_FD_EN    = 1'b0;
        reg_DE_EN    = 1'b0;
        reg_EM_EN    = 1'b0;
        reg_MW_flush = 1'b1;
      end else if (w_data_stall) begin
        PC_EN_IF     = 1'b0;
        reg_FD_EN    = 1'b0;
        reg_DE_flush = 1'b1;
      end else begin
        reg_FD_flush = Branch_ID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex_rd  <= 5'd0;
      r_ex_op  <= OP_NONE;
      r_mem_rd <= 5'd0;
      r_mem_op <= OP_NONE;
      r_state  <= ST_RUN;
    end else begin
      r_state <= w_mem_wait ? ST_MEM_WAIT : ST_RUN;
      if (!w_mem_wait) begin
        r_mem_rd <= r_ex_rd;
        r_mem_op <= r_ex_op;
        if (w_data_stall) begin
          r_ex_rd <= 5'd0;
          r_ex_op <= OP_NONE;
        end else begin
          r_ex_rd <= rd_ID;
          r_ex_op <= hazard_optype_ID;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_stall_cnt <= 16'd0;
    else if ((w_mem_wait || w_data_stall) && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an instruction-level model.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID;
  logic        rs1use_ID, rs2use_ID;
  logic [1:0]  hazard_optype_ID;
  logic        Branch_ID, dmem_ack;
  logic [1:0]  forward_ctrl_A, forward_ctrl_B;
  logic        PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_MW_flush;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  hazard_unit dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .hazard_optype_ID(hazard_optype_ID), .Branch_ID(Branch_ID), .dmem_ack(dmem_ack),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_FD_flush(reg_FD_flush),
    .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush), .reg_EM_EN(reg_EM_EN),
    .reg_MW_flush(reg_MW_flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: the two instructions in flight ahead of ID, [0] = one ahead, [1] = two ahead.
  logic [4:0]  m_rd[2];
  logic [1:0]  m_op[2];
  logic [4:0]  nx_rd[2];
  logic [1:0]  nx_op[2];
  int          m_cnt, nx_cnt;
  bit          model_on = 0;

  function automatic bit writes_reg(input int k);
    return (m_op[k] == 2'b01 || m_op[k] == 2'b10) && m_rd[k] != 5'd0;
  endfunction

  task automatic operand(input logic use_it, input logic [4:0] rs, output bit st, output logic [1:0] f);
    bit found = 0;
    st = 0;
    f = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (!found && use_it && writes_reg(k) && m_rd[k] == rs) begin
        found = 1;
`ifdef HAZARD_FWD_EN
        if (k == 0) begin
          if (m_op[k] == 2'b10) st = 1;
          else f = 2'b01;
        end else begin
          f = (m_op[k] == 2'b10) ? 2'b11 : 2'b10;
        end
`else
        st = 1;
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      bit sa, sb, waiting, dstall;
      logic [1:0] fa, fb;
      logic [6:0] e;  // {PC_EN, FD_EN, FD_flush, DE_EN, DE_flush, EM_EN, MW_flush}
      operand(rs1use_ID, rs1_ID, sa, fa);
      operand(rs2use_ID, rs2_ID, sb, fb);
      waiting = (m_op[1] == 2'b10 || m_op[1] == 2'b11) && !dmem_ack;
      dstall  = (sa || sb) && !waiting;
      if (!rst) begin
        fa = 2'b00; fb = 2'b00; e = 7'b1101010;
      end else if (waiting) e = 7'b0000001;
      else if (dstall)      e = 7'b0001110;
      else                  e = {3'b110, Branch_ID, 3'b010} ^ 7'b0000000 | {2'b00, Branch_ID, 4'b1010};
      chk("fwdA", {14'd0, forward_ctrl_A}, {14'd0, fa});
      chk("fwdB", {14'd0, forward_ctrl_B}, {14'd0, fb});
      chk("PC_EN_IF", {15'd0, PC_EN_IF}, {15'd0, e[6]});
      chk("reg_FD_EN", {15'd0, reg_FD_EN}, {15'd0, e[5]});
      chk("reg_FD_flush", {15'd0, reg_FD_flush}, {15'd0, e[4]});
      chk("reg_DE_EN", {15'd0, reg_DE_EN}, {15'd0, e[3]});
      chk("reg_DE_flush", {15'd0, reg_DE_flush}, {15'd0, e[2]});
      chk("reg_EM_EN", {15'd0, reg_EM_EN}, {15'd0, e[1]});
      chk("reg_MW_flush", {15'd0, reg_MW_flush}, {15'd0, e[0]});
      chk("stall_cnt", stall_cnt, m_cnt[15:0]);
      nx_rd = m_rd; nx_op = m_op; nx_cnt = m_cnt;
      if (!rst) begin
        nx_rd = '{5'd0, 5'd0}; nx_op = '{2'b00, 2'b00}; nx_cnt = 0;
      end else begin
        if (waiting || dstall) nx_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
        if (!waiting) begin
          nx_rd[1] = m_rd[0]; nx_op[1] = m_op[0];
          nx_rd[0] = dstall ? 5'd0 : rd_ID;
          nx_op[0] = dstall ? 2'b00 : hazard_optype_ID;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (model_on) begin
      m_rd = nx_rd; m_op = nx_op; m_cnt = nx_cnt;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic [1:0] op, input logic br);
    rs1_ID = r1; rs2_ID = r2; rd_ID = rd;
    rs1use_ID = u1; rs2use_ID = u2; hazard_optype_ID = op; Branch_ID = br;
  endtask

  task automatic idle();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_PC_EN", {15'd0, PC_EN_IF}, 16'd1);
    chk("rst_DE_flush", {15'd0, reg_DE_flush}, 16'd0);
    chk("rst_fwdA", {14'd0, forward_ctrl_A}, 16'd0);
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    dmem_ack = 1'b1;
    idle();
    m_rd = '{5'd0, 5'd0}; m_op = '{2'b00, 2'b00}; m_cnt = 0;
    nx_rd = m_rd; nx_op = m_op; nx_cnt = 0;
    cyc();
    model_on = 1;
    cyc();

    // producer of x0 never creates a dependency
    do_reset();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0); cyc();
    set_id(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 2'b01, 1'b0);
    @(negedge clk);
    chk("x0_fwdA", {14'd0, forward_ctrl_A}, 16'd0);
    chk("x0_PC_EN", {15'd0, PC_EN_IF}, 16'd1);
    cyc();

    // add x5 ; add x6,x5,x5
    do_reset();
    set_id(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 2'b01, 1'b0); cyc();
    set_id(5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 2'b01, 1'b0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("alu_fwdA", {14'd0, forward_ctrl_A}, 16'd1);
    chk("alu_fwdB", {14'd0, forward_ctrl_B}, 16'd1);
    chk("alu_PC_EN", {15'd0, PC_EN_IF}, 16'd1);
    chk("alu_cnt", stall_cnt, 16'd0);
`else
    chk("alu_PC_EN", {15'd0, PC_EN_IF}, 16'd0);
    cyc(); cyc();
    @(negedge clk);
    chk("alu_PC_EN_after", {15'd0, PC_EN_IF}, 16'd1);
    chk("alu_cnt", stall_cnt, 16'd2);
`endif
    cyc();

    // lw x5 ; addi x6,x5,1
    do_reset();
    set_id(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 2'b10, 1'b0); cyc();
    set_id(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 2'b01, 1'b0);
    @(negedge clk);
    chk("lu_PC_EN", {15'd0, PC_EN_IF}, 16'd0);
    chk("lu_DE_flush", {15'd0, reg_DE_flush}, 16'd1);
    cyc();
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    chk("lu_fwdA", {14'd0, forward_ctrl_A}, 16'd3);
    chk("lu_PC_EN2", {15'd0, PC_EN_IF}, 16'd1);
    chk("lu_cnt", stall_cnt, 16'd1);
`else
    chk("lu_PC_EN2", {15'd0, PC_EN_IF}, 16'd0);
    cyc();
    @(negedge clk);
    chk("lu_cnt", stall_cnt, 16'd2);
`endif
    cyc();

    // add x5 ; beq x5,x0 taken
    do_reset();
    set_id(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 2'b01, 1'b0); cyc();
    set_id(5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 1'b1);
`ifndef HAZARD_FWD_EN
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("br_stall_PC_EN", {15'd0, PC_EN_IF}, 16'd0);
      chk("br_stall_FD_flush", {15'd0, reg_FD_flush}, 16'd0);
      chk("br_stall_DE_flush", {15'd0, reg_DE_flush}, 16'd1);
      cyc();
    end
`endif
    @(negedge clk);
    chk("br_FD_flush", {15'd0, reg_FD_flush}, 16'd1);
    chk("br_PC_EN", {15'd0, PC_EN_IF}, 16'd1);
`ifdef HAZARD_FWD_EN
    chk("br_cnt", stall_cnt, 16'd0);
`else
    chk("br_cnt", stall_cnt, 16'd2);
`endif
    cyc();
    idle();
    @(negedge clk);
    chk("br_FD_flush_off", {15'd0, reg_FD_flush}, 16'd0);
    cyc();

    // sw reaching MEM with ack low for 3 cycles
    do_reset();
    set_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 2'b11, 1'b0); cyc();
    idle(); cyc();
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_PC_EN", {15'd0, PC_EN_IF}, 16'd0);
      chk("mw_DE_EN", {15'd0, reg_DE_EN}, 16'd0);
      chk("mw_EM_EN", {15'd0, reg_EM_EN}, 16'd0);
      chk("mw_MW_flush", {15'd0, reg_MW_flush}, 16'd1);
      cyc();
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("mw_done_PC_EN", {15'd0, PC_EN_IF}, 16'd1);
    chk("mw_done_MW_flush", {15'd0, reg_MW_flush}, 16'd0);
    chk("mw_cnt", stall_cnt, 16'd3);
    cyc();
    @(negedge clk);
    chk("mw_after_EM_EN", {15'd0, reg_EM_EN}, 16'd1);
    cyc();

    // reset while waiting on memory
    do_reset();
    set_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 2'b11, 1'b0); cyc();
    idle(); cyc();
    dmem_ack = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rw_rst_PC_EN", {15'd0, PC_EN_IF}, 16'd1);
    chk("rw_rst_MW_flush", {15'd0, reg_MW_flush}, 16'd0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rw_PC_EN", {15'd0, PC_EN_IF}, 16'd1);
    chk("rw_EM_EN", {15'd0, reg_EM_EN}, 16'd1);
    chk("rw_cnt", stall_cnt, 16'd0);
    cyc();
    dmem_ack = 1'b1;

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      dmem_ack = ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0;
      cyc();
    end

    @(negedge clk);
    model_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset; synchronous, active-low.
REQ-003 SHALL have inputs rs1_ID, rs2_ID, rd_ID, each 5 bits: ID-stage source and destination register numbers.
REQ-004 SHALL have inputs rs1use_ID and rs2use_ID, 1 bit each: ID instruction reads rs1/rs2.
REQ-005 SHALL have input hazard_optype_ID, 2 bits, encoded as 00 none, 01 ALU-writeback, 10 load, 11 store.
REQ-006 SHALL have input Branch_ID, 1 bit: taken branch/JAL/JALR resolved in ID.
REQ-007 SHALL have input dmem_ack, 1 bit: data memory completes the MEM-stage access this cycle.
REQ-008 SHALL have outputs forward_ctrl_A and forward_ctrl_B, 2 bits each: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
REQ-009 SHALL have outputs PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN and reg_MW_flush, 1 bit each: pipeline register controls.
REQ-010 SHALL have output stall_cnt, 16 bits: saturating count of stalled cycles.

Function
REQ-011 SHALL track EX and MEM slots, each holding {rd, optype}; every enabled cycle, ID moves to EX and EX moves to MEM.
REQ-012 SHALL load a none slot into EX when reg_DE_flush=1, and SHALL hold both slots while in MEM_WAIT.
REQ-013 SHALL treat a slot as a producer only when optype is 01 or 10 and rd is not 0.
REQ-014 SHALL flag a match when (rs1use_ID and rs1_ID equals a producer rd) or (rs2use_ID and rs2_ID equals a producer rd); the EX slot has priority over the MEM slot.
REQ-015 SHALL raise a load-use stall when the EX slot holds a matching load (10).
REQ-016 SHALL, on a data stall, drive PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1, and force reg_FD_flush=0 even if Branch_ID=1.
REQ-017 SHALL drive reg_FD_flush=1 when Branch_ID=1 with no stall and no MEM_WAIT, with all other controls at run values.
REQ-018 SHALL use an FSM with states RUN and MEM_WAIT; RUN goes to MEM_WAIT when the MEM slot optype is 10 or 11 and dmem_ack=0; MEM_WAIT returns to RUN on the cycle after dmem_ack=1.
REQ-019 SHALL, in MEM_WAIT (and in the RUN cycle that detects the wait), drive PC_EN_IF, reg_FD_EN, reg_DE_EN and reg_EM_EN to 0 and reg_MW_flush to 1; MEM_WAIT has priority over data stall and branch flush.
REQ-020 SHALL, in RUN with no stall, drive all *_EN to 1 and all *_flush to 0, except reg_FD_flush per REQ-017.
REQ-021 SHALL increment stall_cnt in every cycle with a data stall or MEM_WAIT, saturating at 16'hFFFF.
REQ-022 SHALL, when both rs1 and rs2 match different slots, apply stall and forward decisions independently per operand.

Reset
REQ-023 SHALL, while rst=0 at a clock edge, set both slots to none, the FSM to RUN and stall_cnt to 0.
REQ-024 SHALL, during reset, drive forward_ctrl_A/B=00, all *_EN=1 and all *_flush=0; reset mid-MEM_WAIT SHALL abort the wait.

Configuration
REQ-025 SHALL compile forwarding in when HAZARD_FWD_EN is defined: forward_ctrl per REQ-008; EX match selects 01 unless the slot is a load (stall); MEM match selects 10 for ALU or 11 for load.
REQ-026 SHALL, without HAZARD_FWD_EN, tie forward_ctrl_A/B to 00 and stall on any EX or MEM producer match, giving 2 bubbles after an EX match and 1 after a MEM match.

Verification
REQ-027 SHALL cover: FWD_EN, add x5 then add x6,x5,x5 -> forward_ctrl_A=B=01, no stall, stall_cnt=0.
REQ-028 SHALL cover: FWD_EN, lw x5 then addi x6,x5,1 -> 1 stall cycle (PC_EN_IF=0, reg_DE_flush=1), then forward_ctrl_A=11, stall_cnt=1.
REQ-029 SHALL cover: no FWD_EN, add x5 then beq x5,x0 with Branch_ID=1 -> 2 stall cycles with reg_FD_flush=0, then reg_FD_flush=1 for 1 cycle, stall_cnt=2.
REQ-030 SHALL cover: sw in MEM with dmem_ack low for 3 cycles -> all EN=0 and reg_MW_flush=1 for 3 cycles, then RUN, stall_cnt=3.
REQ-031 SHALL cover: producer rd=x0 with a consumer of x0 -> forward 00, no stall.
REQ-032 SHALL cover: rst=0 asserted during MEM_WAIT -> next cycle in RUN with stall_cnt=0 and all EN=1.
